// File: rtl/axi_slv_port_router.sv
// Slave-port front end of the AXI crossbar: decodes AW/AR against the rule map, locks each
// direction to one downstream port while transactions are outstanding, and answers misses with DECERR.

package axi_slv_port_router_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } rule_t;

  localparam logic [1:0] RespDecErr = 2'b11;

endpackage

module axi_slv_port_router #(
  parameter int unsigned NoMstPorts   = 4,
  parameter int unsigned NoAddrRules  = 4,
  parameter int unsigned MaxTrans     = 8,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiAddrWidth = 32,
  parameter type req_t  = axi_slv_port_router_pkg::req_t,
  parameter type resp_t = axi_slv_port_router_pkg::resp_t,
  parameter type rule_t = axi_slv_port_router_pkg::rule_t,
  localparam int unsigned DefW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  req_t            slv_req_i,
  output resp_t           slv_resp_o,
  output req_t            mst_reqs_o [NoMstPorts],
  input  resp_t           mst_resps_i [NoMstPorts],
  input  rule_t           addr_map_i [NoAddrRules],
  input  logic            en_default_mst_port_i,
  input  logic [DefW-1:0] default_mst_port_i
);

  localparam int unsigned SelW = $clog2(NoMstPorts + 1);
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [SelW-1:0] ErrSel = SelW'(NoMstPorts);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTrans);

  typedef enum logic [1:0] {WrIdle, WrData, WrResp, WrAtopHandoff} errWrState_e;
  typedef enum logic {RdIdle, RdData} errRdState_e;

  logic [SelW-1:0] wSel_q, wSel_d, rSel_q, rSel_d;
  logic [CntW-1:0] wCnt_q, wCnt_d, rCnt_q, rCnt_d;
  logic [SelW-1:0] awSel, arSel;
  logic            awAtop, wLockOk, rLockAw, awOk, arOk, wActive, rActive;
  logic            awHs, arHs, bHs, rLastHs;

  req_t  extReq  [NoMstPorts+1];
  resp_t extResp [NoMstPorts+1];
  req_t  errReq;
  resp_t errResp;
  logic  errReqUnused;

  errWrState_e           errWrState_q, errWrState_d;
  errRdState_e           errRdState_q, errRdState_d;
  logic [AxiIdWidth-1:0] errWId_q, errWId_d, errRId_q, errRId_d;
  logic [7:0]            errWLen_q, errWLen_d, errRCnt_q, errRCnt_d;
  logic                  errWAtop_q, errWAtop_d;

  // Highest-indexed matching rule wins; rules pointing past the last port never match.
  function automatic logic [SelW-1:0] decodeAddr(input logic [AxiAddrWidth-1:0] addr);
    logic            hit;
    logic [SelW-1:0] sel;
    hit = 1'b0;
    sel = ErrSel;
    for (int unsigned i = 0; i < NoAddrRules; i++) begin
      if ((addr_map_i[i].idx < NoMstPorts) && (addr >= addr_map_i[i].start_addr) &&
          (addr < addr_map_i[i].end_addr)) begin
        hit = 1'b1;
        sel = SelW'(addr_map_i[i].idx);
      end
    end
    if (!hit) begin
      sel = en_default_mst_port_i ? SelW'(default_mst_port_i) : ErrSel;
    end
    return sel;
  endfunction

  assign awSel  = decodeAddr(slv_req_i.aw.addr);
  assign arSel  = decodeAddr(slv_req_i.ar.addr);
  assign awAtop = slv_req_i.aw.atop[5];

  assign wLockOk = (wCnt_q == '0) || ((awSel == wSel_q) && (wCnt_q < MaxCnt));
  assign rLockAw = (rCnt_q == '0) || ((awSel == rSel_q) && (rCnt_q < MaxCnt));
  assign awOk    = !rst_i && wLockOk && (!awAtop || rLockAw);
  // An atomic AW claims the read lock too, so a competing AR waits until the AW is through.
  assign arOk    = !rst_i && !(slv_req_i.aw_valid && awAtop) &&
                   ((rCnt_q == '0) || ((arSel == rSel_q) && (rCnt_q < MaxCnt)));
  assign wActive = !rst_i && (wCnt_q != '0);
  assign rActive = !rst_i && (rCnt_q != '0);

  always_comb begin
    for (int unsigned p = 0; p < NoMstPorts; p++) begin
      extResp[p] = mst_resps_i[p];
    end
    extResp[NoMstPorts] = errResp;
  end

  always_comb begin
    slv_resp_o = '0;
    for (int unsigned p = 0; p <= NoMstPorts; p++) begin
      extReq[p]          = slv_req_i;
      extReq[p].aw_valid = 1'b0;
      extReq[p].w_valid  = 1'b0;
      extReq[p].b_ready  = 1'b0;
      extReq[p].ar_valid = 1'b0;
      extReq[p].r_ready  = 1'b0;
      if (awSel == SelW'(p)) begin
        extReq[p].aw_valid  = slv_req_i.aw_valid && awOk;
        slv_resp_o.aw_ready = awOk && extResp[p].aw_ready;
      end
      if (arSel == SelW'(p)) begin
        extReq[p].ar_valid  = slv_req_i.ar_valid && arOk;
        slv_resp_o.ar_ready = arOk && extResp[p].ar_ready;
      end
      if (wSel_q == SelW'(p)) begin
        extReq[p].w_valid  = slv_req_i.w_valid && wActive;
        extReq[p].b_ready  = slv_req_i.b_ready && wActive;
        slv_resp_o.w_ready = wActive && extResp[p].w_ready;
        slv_resp_o.b_valid = wActive && extResp[p].b_valid;
        slv_resp_o.b       = extResp[p].b;
      end
      if (rSel_q == SelW'(p)) begin
        extReq[p].r_ready  = slv_req_i.r_ready && rActive;
        slv_resp_o.r_valid = rActive && extResp[p].r_valid;
        slv_resp_o.r       = extResp[p].r;
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NoMstPorts; p++) begin
      mst_reqs_o[p] = extReq[p];
    end
    errReq = extReq[NoMstPorts];
  end

  assign errReqUnused = ^errReq;

  assign awHs    = slv_req_i.aw_valid && slv_resp_o.aw_ready;
  assign arHs    = slv_req_i.ar_valid && slv_resp_o.ar_ready;
  assign bHs     = slv_resp_o.b_valid && slv_req_i.b_ready;
  assign rLastHs = slv_resp_o.r_valid && slv_req_i.r_ready && slv_resp_o.r.last;

  always_comb begin
    wSel_d = awHs ? awSel : wSel_q;
    wCnt_d = wCnt_q;
    if (awHs && !bHs) begin
      wCnt_d = wCnt_q + CntW'(1);
    end else if (!awHs && bHs) begin
      wCnt_d = wCnt_q - CntW'(1);
    end
    rSel_d = rSel_q;
    if (arHs) begin
      rSel_d = arSel;
    end else if (awHs && awAtop) begin
      rSel_d = awSel;
    end
    rCnt_d = rCnt_q;
    if ((arHs || (awHs && awAtop)) && !rLastHs) begin
      rCnt_d = rCnt_q + CntW'(1);
    end else if (!(arHs || (awHs && awAtop)) && rLastHs) begin
      rCnt_d = rCnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wSel_q <= '0;
      rSel_q <= '0;
      wCnt_q <= '0;
      rCnt_q <= '0;
    end else begin
      wSel_q <= wSel_d;
      rSel_q <= rSel_d;
      wCnt_q <= wCnt_d;
      rCnt_q <= rCnt_d;
    end
  end

  // Error responder outputs come from state only, which keeps the routing free of comb loops.
  always_comb begin
    errResp            = '0;
    errResp.aw_ready   = (errWrState_q == WrIdle);
    errResp.w_ready    = (errWrState_q == WrData);
    errResp.b_valid    = (errWrState_q == WrResp);
    errResp.b.id       = errWId_q;
    errResp.b.resp     = axi_slv_port_router_pkg::RespDecErr;
    errResp.ar_ready   = (errRdState_q == RdIdle) && (errWrState_q != WrAtopHandoff);
    errResp.r_valid    = (errRdState_q == RdData);
    errResp.r.id       = errRId_q;
    errResp.r.data     = '0;
    errResp.r.resp     = axi_slv_port_router_pkg::RespDecErr;
    errResp.r.last     = (errRCnt_q == 8'd0);
  end

  always_comb begin
    errWrState_d = errWrState_q;
    errRdState_d = errRdState_q;
    errWId_d     = errWId_q;
    errWLen_d    = errWLen_q;
    errWAtop_d   = errWAtop_q;
    errRId_d     = errRId_q;
    errRCnt_d    = errRCnt_q;
    case (errRdState_q)
      RdIdle: begin
        if (errReq.ar_valid && (errWrState_q != WrAtopHandoff)) begin
          errRdState_d = RdData;
          errRId_d     = errReq.ar.id;
          errRCnt_d    = errReq.ar.len;
        end
      end
      RdData: begin
        if (errReq.r_ready) begin
          if (errRCnt_q == 8'd0) begin
            errRdState_d = RdIdle;
          end else begin
            errRCnt_d = errRCnt_q - 8'd1;
          end
        end
      end
      default: errRdState_d = RdIdle;
    endcase
    case (errWrState_q)
      WrIdle: begin
        if (errReq.aw_valid) begin
          errWrState_d = WrData;
          errWId_d     = errReq.aw.id;
          errWLen_d    = errReq.aw.len;
          errWAtop_d   = errReq.aw.atop[5];
        end
      end
      WrData: begin
        if (errReq.w_valid && errReq.w.last) begin
          errWrState_d = WrResp;
        end
      end
      WrResp: begin
        if (errReq.b_ready) begin
          errWrState_d = errWAtop_q ? WrAtopHandoff : WrIdle;
        end
      end
      WrAtopHandoff: begin
        // Atomic read data reuses the read burst engine once it is free.
        if (errRdState_q == RdIdle) begin
          errRdState_d = RdData;
          errRId_d     = errWId_q;
          errRCnt_d    = errWLen_q;
          errWrState_d = WrIdle;
        end
      end
      default: errWrState_d = WrIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      errWrState_q <= WrIdle;
      errRdState_q <= RdIdle;
      errWId_q     <= '0;
      errWLen_q    <= '0;
      errWAtop_q   <= 1'b0;
      errRId_q     <= '0;
      errRCnt_q    <= '0;
    end else begin
      errWrState_q <= errWrState_d;
      errRdState_q <= errRdState_d;
      errWId_q     <= errWId_d;
      errWLen_q    <= errWLen_d;
      errWAtop_q   <= errWAtop_d;
      errRId_q     <= errRId_d;
      errRCnt_q    <= errRCnt_d;
    end
  end

endmodule

// File: tb/tb_axi_slv_port_router.sv
// Directed bench for axi_slv_port_router: decode, default/error routing, locks, full stall and ATOP.

module tb_axi_slv_port_router;
  import axi_slv_port_router_pkg::*;

  localparam int unsigned NoMstPorts  = 4;
  localparam int unsigned NoAddrRules = 4;

  logic       clk;
  logic       rst;
  req_t       slvReq;
  resp_t      slvResp;
  req_t       mstReqs  [NoMstPorts];
  resp_t      mstResps [NoMstPorts];
  rule_t      addrMap  [NoAddrRules];
  logic       enDefault;
  logic [1:0] defaultPort;
  int         nChecks = 0;
  int         nErrors = 0;
  int         waitCnt;

  axi_slv_port_router #(
    .NoMstPorts  (NoMstPorts),
    .NoAddrRules (NoAddrRules),
    .MaxTrans    (2),
    .AxiIdWidth  (4),
    .AxiAddrWidth(32)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .slv_req_i            (slvReq),
    .slv_resp_o           (slvResp),
    .mst_reqs_o           (mstReqs),
    .mst_resps_i          (mstResps),
    .addr_map_i           (addrMap),
    .en_default_mst_port_i(enDefault),
    .default_mst_port_i   (defaultPort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [3:0] awVec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mstReqs[i].aw_valid;
    return v;
  endfunction

  function automatic logic [3:0] arVec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mstReqs[i].ar_valid;
    return v;
  endfunction

  function automatic logic [3:0] wVec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mstReqs[i].w_valid;
    return v;
  endfunction

  function automatic logic [3:0] bReadyVec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mstReqs[i].b_ready;
    return v;
  endfunction

  function automatic logic [3:0] rReadyVec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mstReqs[i].r_ready;
    return v;
  endfunction

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    slvReq = '0;
    for (int i = 0; i < 4; i++) begin
      mstResps[i]          = '0;
      mstResps[i].aw_ready = 1'b1;
      mstResps[i].ar_ready = 1'b1;
      mstResps[i].w_ready  = 1'b1;
    end
    addrMap[0]  = '{idx: 32'd0, start_addr: 32'h0000, end_addr: 32'h1000};
    addrMap[1]  = '{idx: 32'd1, start_addr: 32'h1000, end_addr: 32'h2000};
    addrMap[2]  = '{idx: 32'd9, start_addr: 32'h0000, end_addr: 32'h2000};
    addrMap[3]  = '{idx: 32'd3, start_addr: 32'h4000, end_addr: 32'h5000};
    enDefault   = 1'b0;
    defaultPort = 2'd0;
    rst         = 1'b1;

    // Reset: requests pending upstream must not leak through.
    slvReq.aw_valid = 1'b1;
    slvReq.ar_valid = 1'b1;
    stepClock();
    stepClock();
    checkOutput("resetAwReady", 64'(slvResp.aw_ready), 64'd0);
    checkOutput("resetArReady", 64'(slvResp.ar_ready), 64'd0);
    checkOutput("resetAwVec", 64'(awVec()), 64'd0);
    checkOutput("resetArVec", 64'(arVec()), 64'd0);
    checkOutput("resetBValid", 64'(slvResp.b_valid), 64'd0);
    checkOutput("resetRValid", 64'(slvResp.r_valid), 64'd0);
    slvReq.aw_valid = 1'b0;
    slvReq.ar_valid = 1'b0;
    stepClock();
    rst = 1'b0;

    // Decode and rule priority.
    slvReq.ar.addr  = 32'h1800;
    slvReq.ar_valid = 1'b1;
    #1;
    checkOutput("decode1800", 64'(arVec()), 64'h2);
    checkOutput("decodeArReady", 64'(slvResp.ar_ready), 64'd1);
    slvReq.ar.addr = 32'h0FFF;
    #1;
    checkOutput("decode0FFF", 64'(arVec()), 64'h1);
    slvReq.ar.addr = 32'h1000;
    #1;
    checkOutput("decodeEndExclusive", 64'(arVec()), 64'h2);
    slvReq.ar.addr = 32'h0800;
    #1;
    checkOutput("ignoredRuleIdx", 64'(arVec()), 64'h1);
    addrMap[2].idx = 32'd2;
    #1;
    checkOutput("overlapHighest", 64'(arVec()), 64'h4);
    slvReq.ar.addr = 32'h4800;
    #1;
    checkOutput("decode4800", 64'(arVec()), 64'h8);
    slvReq.ar_valid = 1'b0;
    addrMap[2].idx  = 32'd9;

    // Miss with default port.
    enDefault       = 1'b1;
    defaultPort     = 2'd3;
    slvReq.aw.addr  = 32'h9000;
    slvReq.aw_valid = 1'b1;
    #1;
    checkOutput("missDefaultVec", 64'(awVec()), 64'h8);
    checkOutput("missDefaultReady", 64'(slvResp.aw_ready), 64'd1);
    slvReq.aw_valid = 1'b0;
    #1;
    enDefault = 1'b0;

    // Miss to error responder: write.
    slvReq.aw.id    = 4'd5;
    slvReq.aw.len   = 8'd3;
    slvReq.aw_valid = 1'b1;
    #1;
    checkOutput("errAwVec", 64'(awVec()), 64'd0);
    checkOutput("errAwReady", 64'(slvResp.aw_ready), 64'd1);
    stepClock();
    slvReq.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slvReq.w_valid = 1'b1;
      slvReq.w.last  = (i == 3);
      slvReq.w.data  = 32'(i);
      #1;
      checkOutput("errWReady", 64'(slvResp.w_ready), 64'd1);
      if (i == 0) checkOutput("errWVec", 64'(wVec()), 64'd0);
      stepClock();
    end
    slvReq.w_valid = 1'b0;
    slvReq.w.last  = 1'b0;
    #1;
    checkOutput("errBValid", 64'(slvResp.b_valid), 64'd1);
    checkOutput("errBId", 64'(slvResp.b.id), 64'd5);
    checkOutput("errBResp", 64'(slvResp.b.resp), 64'd3);
    slvReq.b_ready = 1'b1;
    stepClock();
    slvReq.b_ready = 1'b0;
    checkOutput("errBDone", 64'(slvResp.b_valid), 64'd0);

    // Miss to error responder: read burst of three.
    slvReq.ar.addr  = 32'h9000;
    slvReq.ar.id    = 4'd6;
    slvReq.ar.len   = 8'd2;
    slvReq.ar_valid = 1'b1;
    #1;
    checkOutput("errArReady", 64'(slvResp.ar_ready), 64'd1);
    stepClock();
    slvReq.ar_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("errRValid", 64'(slvResp.r_valid), 64'd1);
      checkOutput("errRResp", 64'(slvResp.r.resp), 64'd3);
      checkOutput("errRLast", 64'(slvResp.r.last), 64'(i == 2));
      checkOutput("errRId", 64'(slvResp.r.id), 64'd6);
      if (i == 0) checkOutput("errRData", 64'(slvResp.r.data), 64'd0);
      slvReq.r_ready = 1'b1;
      stepClock();
    end
    slvReq.r_ready = 1'b0;
    checkOutput("errRDone", 64'(slvResp.r_valid), 64'd0);

    // Write lock: second AW to another port waits for the first B.
    slvReq.aw.addr  = 32'h0100;
    slvReq.aw.id    = 4'd1;
    slvReq.aw.len   = 8'd0;
    slvReq.aw.atop  = 6'd0;
    slvReq.aw_valid = 1'b1;
    #1;
    checkOutput("lockFirstVec", 64'(awVec()), 64'h1);
    stepClock();
    slvReq.aw.addr = 32'h1100;
    slvReq.aw.id   = 4'd2;
    #1;
    checkOutput("lockStallReady", 64'(slvResp.aw_ready), 64'd0);
    checkOutput("lockStallVec", 64'(awVec()), 64'd0);
    stepClock();
    checkOutput("lockStallHold", 64'(slvResp.aw_ready), 64'd0);
    mstResps[0].b_valid = 1'b1;
    mstResps[0].b.id    = 4'd1;
    slvReq.b_ready      = 1'b1;
    #1;
    checkOutput("lockBValid", 64'(slvResp.b_valid), 64'd1);
    checkOutput("lockBId", 64'(slvResp.b.id), 64'd1);
    checkOutput("lockBReadyVec", 64'(bReadyVec()), 64'h1);
    stepClock();
    mstResps[0].b_valid = 1'b0;
    #1;
    checkOutput("lockReleaseReady", 64'(slvResp.aw_ready), 64'd1);
    checkOutput("lockReleaseVec", 64'(awVec()), 64'h2);
    stepClock();
    slvReq.aw_valid = 1'b0;
    slvReq.w_valid  = 1'b1;
    slvReq.w.last   = 1'b1;
    #1;
    checkOutput("lockWVec", 64'(wVec()), 64'h2);
    stepClock();
    slvReq.w_valid      = 1'b0;
    mstResps[1].b_valid = 1'b1;
    mstResps[1].b.id    = 4'd2;
    #1;
    checkOutput("lockB2Id", 64'(slvResp.b.id), 64'd2);
    stepClock();
    mstResps[1].b_valid = 1'b0;
    slvReq.b_ready      = 1'b0;
    #1;
    checkOutput("lockBDone", 64'(slvResp.b_valid), 64'd0);

    // Read full: MaxTrans=2 outstanding ARs to port 0.
    slvReq.ar.addr  = 32'h0100;
    slvReq.ar.len   = 8'd0;
    slvReq.ar_valid = 1'b1;
    #1;
    checkOutput("fullFirstAr", 64'(slvResp.ar_ready), 64'd1);
    stepClock();
    checkOutput("fullSecondAr", 64'(slvResp.ar_ready), 64'd1);
    stepClock();
    checkOutput("fullStall", 64'(slvResp.ar_ready), 64'd0);
    checkOutput("fullStallVec", 64'(arVec()), 64'd0);
    mstResps[0].r_valid = 1'b1;
    mstResps[0].r.last  = 1'b1;
    mstResps[0].r.id    = 4'd3;
    mstResps[0].r.data  = 32'hCAFE;
    slvReq.r_ready      = 1'b1;
    #1;
    checkOutput("fullRValid", 64'(slvResp.r_valid), 64'd1);
    checkOutput("fullRData", 64'(slvResp.r.data), 64'hCAFE);
    checkOutput("fullRReadyVec", 64'(rReadyVec()), 64'h1);
    stepClock();
    mstResps[0].r_valid = 1'b0;
    #1;
    checkOutput("fullRelease", 64'(slvResp.ar_ready), 64'd1);
    stepClock();
    slvReq.ar_valid     = 1'b0;
    mstResps[0].r_valid = 1'b1;
    stepClock();
    stepClock();
    checkOutput("fullDrained", 64'(slvResp.r_valid), 64'd0);
    mstResps[0].r_valid = 1'b0;
    slvReq.r_ready      = 1'b0;

    // ATOP to the error target: B then len+1 R beats on the read path.
    slvReq.aw.addr  = 32'h9000;
    slvReq.aw.id    = 4'd7;
    slvReq.aw.len   = 8'd1;
    slvReq.aw.atop  = 6'b100000;
    slvReq.aw_valid = 1'b1;
    #1;
    checkOutput("atopAwReady", 64'(slvResp.aw_ready), 64'd1);
    stepClock();
    slvReq.aw_valid = 1'b0;
    slvReq.aw.atop  = 6'd0;
    slvReq.w_valid  = 1'b1;
    slvReq.w.last   = 1'b0;
    stepClock();
    slvReq.w.last = 1'b1;
    stepClock();
    slvReq.w_valid = 1'b0;
    slvReq.w.last  = 1'b0;
    #1;
    checkOutput("atopBValid", 64'(slvResp.b_valid), 64'd1);
    checkOutput("atopBResp", 64'(slvResp.b.resp), 64'd3);
    checkOutput("atopBId", 64'(slvResp.b.id), 64'd7);
    slvReq.b_ready = 1'b1;
    stepClock();
    slvReq.b_ready = 1'b0;
    slvReq.r_ready = 1'b1;
    waitCnt = 0;
    while (!slvResp.r_valid && waitCnt < 10) begin
      stepClock();
      waitCnt++;
    end
    checkOutput("atopRStart", 64'(slvResp.r_valid), 64'd1);
    for (int i = 0; i < 2; i++) begin
      checkOutput("atopRResp", 64'(slvResp.r.resp), 64'd3);
      checkOutput("atopRLast", 64'(slvResp.r.last), 64'(i == 1));
      checkOutput("atopRId", 64'(slvResp.r.id), 64'd7);
      stepClock();
    end
    slvReq.r_ready = 1'b0;
    checkOutput("atopRDone", 64'(slvResp.r_valid), 64'd0);
    slvReq.ar.addr  = 32'h1100;
    slvReq.ar.id    = 4'd4;
    slvReq.ar_valid = 1'b1;
    #1;
    checkOutput("atopRcntCleared", 64'(slvResp.ar_ready), 64'd1);
    checkOutput("atopRcntVec", 64'(arVec()), 64'h2);
    slvReq.ar_valid = 1'b0;
    stepClock();

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
